// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI 1.0 TMDS encoder for the blue, green and red channels.
// It is a two-stage pipeline that moves only on the pixel strobe (I_tick).
// Stage 1 latches the control bits and builds the transition-minimised q_m word.
// Stage 2 applies DC balancing against a running disparity, or emits a control
// symbol during blanking.
// Channel index 0 is blue, 1 is green and 2 is red.
module tmds_encoder #(
  parameter bit P_invert_sync = 1'b0,
  parameter int P_stages      = 2
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_tick,
  input  logic       I_vid_blank,
  input  logic       I_vid_hsync,
  input  logic       I_vid_vsync,
  input  logic [7:0] I_vid_red,
  input  logic [7:0] I_vid_green,
  input  logic [7:0] I_vid_blue,
  output logic [9:0] O_tmds_blue,
  output logic [9:0] O_tmds_green,
  output logic [9:0] O_tmds_red,
  output logic       O_tick
);

  // The pipeline is hard-wired for two pixel ticks of latency.
  generate
    if (P_stages != 2) begin : g_bad_stages
      $error("tmds_encoder: only P_stages == 2 is supported");
    end
  endgenerate

  // Control symbols, indexed by {C1, C0}.
  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  // Number of ones in a byte.
  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Builds q_m. The XNOR chain is used for ones-heavy bytes, so that the word
  // has fewer transitions. q_m[8] records which chain was used.
  function automatic logic [8:0] transition_min(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones     = popcount8(d);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Maps {C1, C0} to its control symbol.
  function automatic logic [9:0] control_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

  // Apply the optional sync polarity inversion before the syncs are latched.
  logic hsync_in;
  logic vsync_in;
  assign hsync_in = I_vid_hsync ^ P_invert_sync;
  assign vsync_in = I_vid_vsync ^ P_invert_sync;

  logic [2:0][7:0] vid_data;
  assign vid_data = {I_vid_red, I_vid_green, I_vid_blue};

  logic blank_s1_reg;
  logic hsync_s1_reg;
  logic vsync_s1_reg;
  logic tick_reg;

  // Stage 1 control bits. Reset loads a blanked pixel, so the first pixel
  // out of the pipeline after reset is a control symbol, not stale data.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      blank_s1_reg <= 1'b1;
      hsync_s1_reg <= 1'b0;
      vsync_s1_reg <= 1'b0;
    end else if (I_tick) begin
      blank_s1_reg <= I_vid_blank;
      hsync_s1_reg <= hsync_in;
      vsync_s1_reg <= vsync_in;
    end
  end

  // Output strobe: I_tick delayed one cycle, which lines up with the symbol update.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= I_tick;
    end
  end

  logic [2:0][9:0] sym_all;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic        [8:0] qm_reg;
      logic        [8:0] qm_next;
      logic signed [4:0] cnt_reg;
      logic signed [4:0] cnt_next;
      logic        [9:0] sym_reg;
      logic        [9:0] sym_next;
      logic        [1:0] ctrl_sel;
      logic signed [5:0] n1;
      logic signed [5:0] n0;
      logic signed [5:0] cnt_wide;
      logic signed [5:0] delta;

      assign qm_next = transition_min(vid_data[gi]);

      // Only the blue channel carries the syncs. Green and red send C1C0 = 00.
      if (gi == 0) begin : g_sync_ctrl
        assign ctrl_sel = {vsync_s1_reg, hsync_s1_reg};
      end else begin : g_zero_ctrl
        assign ctrl_sel = 2'b00;
      end

      // Stage 2 next state: a control symbol during blanking, otherwise a
      // DC-balanced data symbol. The disparity is computed at 6 bits, then
      // narrowed to 5 bits, because it is bounded to -10..+10.
      always_comb begin
        n1       = $signed({2'b00, popcount8(qm_reg[7:0])});
        n0       = 6'sd8 - n1;
        cnt_wide = {cnt_reg[4], cnt_reg};
        sym_next = control_symbol(ctrl_sel);
        delta    = 6'sd0;
        cnt_next = 5'sd0;
        if (!blank_s1_reg) begin
          if ((cnt_reg == 5'sd0) || (n1 == n0)) begin
            sym_next = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
            delta    = qm_reg[8] ? (n1 - n0) : (n0 - n1);
          end else if (((cnt_reg > 5'sd0) && (n1 > n0)) ||
                       ((cnt_reg < 5'sd0) && (n0 > n1))) begin
            sym_next = {1'b1, qm_reg[8], ~qm_reg[7:0]};
            delta    = (qm_reg[8] ? 6'sd2 : 6'sd0) + (n0 - n1);
          end else begin
            sym_next = {1'b0, qm_reg[8], qm_reg[7:0]};
            delta    = (n1 - n0) - (qm_reg[8] ? 6'sd0 : 6'sd2);
          end
          cnt_next = 5'(cnt_wide + delta);
        end
      end

      // Per-channel pipeline registers. They advance only on the pixel strobe.
      always_ff @(posedge I_clock) begin
        if (I_reset) begin
          qm_reg  <= 9'd0;
          cnt_reg <= 5'sd0;
          sym_reg <= CTRL_SYM_00;
        end else if (I_tick) begin
          qm_reg  <= qm_next;
          cnt_reg <= cnt_next;
          sym_reg <= sym_next;
        end
      end

      assign sym_all[gi] = sym_reg;
    end
  endgenerate

  assign O_tmds_blue  = sym_all[0];
  assign O_tmds_green = sym_all[1];
  assign O_tmds_red   = sym_all[2];
  assign O_tick       = tick_reg;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed checks of the TMDS encoder, then a random stream
// compared against a behavioural model. Inputs are driven on the falling edge
// and outputs are sampled on the following falling edge.
module tb_tmds_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tick;
  logic       blank;
  logic       hs;
  logic       vs;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [9:0] o_blue;
  logic [9:0] o_green;
  logic [9:0] o_red;
  logic       o_tick;
  logic [9:0] i_blue;
  logic [9:0] i_green;
  logic [9:0] i_red;
  logic       i_tick;

  int n_checks = 0;
  int n_fail   = 0;

  tmds_encoder #(.P_invert_sync(1'b0), .P_stages(2)) dut (
    .I_clock(clk), .I_reset(rst), .I_tick(tick), .I_vid_blank(blank),
    .I_vid_hsync(hs), .I_vid_vsync(vs), .I_vid_red(red), .I_vid_green(green),
    .I_vid_blue(blue), .O_tmds_blue(o_blue), .O_tmds_green(o_green),
    .O_tmds_red(o_red), .O_tick(o_tick)
  );

  tmds_encoder #(.P_invert_sync(1'b1), .P_stages(2)) dut_inv (
    .I_clock(clk), .I_reset(rst), .I_tick(tick), .I_vid_blank(blank),
    .I_vid_hsync(hs), .I_vid_vsync(vs), .I_vid_red(red), .I_vid_green(green),
    .I_vid_blue(blue), .O_tmds_blue(i_blue), .O_tmds_green(i_green),
    .O_tmds_red(i_red), .O_tick(i_tick)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_px(input logic b, input logic h, input logic v,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] bl);
    blank = b; hs = h; vs = v; red = r; green = g; blue = bl;
  endtask

  // Holds the strobe for one cycle, then returns at the next falling edge.
  task automatic step(input logic t);
    tick = t;
    @(negedge clk);
  endtask

  // Reference model.
  function automatic logic [8:0] m_qm(input logic [7:0] d);
    logic [8:0] q;
    int  ones;
    bit  xn;
    ones = $countones(d);
    xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    return q;
  endfunction

  function automatic logic [9:0] m_ctrl(input logic c1, input logic c0);
    logic [9:0] s;
    if (!c1 && !c0)     s = 10'h354;
    else if (!c1 && c0) s = 10'h0AB;
    else if (c1 && !c0) s = 10'h154;
    else                s = 10'h2AB;
    return s;
  endfunction

  function automatic logic [9:0] m_enc(input logic [8:0] qm, input int cnt_in, output int cnt_out);
    logic [9:0] s;
    int n1;
    int n0;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (cnt_in == 0 || n1 == n0) begin
      s       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      s       = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      s       = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in + n1 - n0 - (qm[8] ? 0 : 2);
    end
    return s;
  endfunction

  logic [8:0] m_qm1 [3];
  int         m_cnt [3];
  logic [9:0] m_out [3];
  logic       m_b1, m_h1, m_v1, m_tk;
  logic [7:0] din [3];
  logic       t;
  int         c_new;

  initial begin
    rst = 1'b1;
    tick = 1'b1;
    set_px(1'b0, 1'b1, 1'b1, 8'h55, 8'hAA, 8'h0F);
    @(negedge clk);
    // Reset takes priority over a live strobe.
    step(1'b1);
    chk("rst_blue", o_blue, 10'h354);
    chk("rst_green", o_green, 10'h354);
    chk("rst_red", o_red, 10'h354);
    chk("rst_tick", {9'd0, o_tick}, 10'd0);
    chk("rst_inv_tick", {9'd0, i_tick}, 10'd0);

    // After release, with no strobe, the reset symbols hold.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("idle_blue", o_blue, 10'h354);
      chk("idle_tick", {9'd0, o_tick}, 10'd0);
    end

    // Blanking with hsync=1 and vsync=0.
    set_px(1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56);
    step(1'b1);
    chk("blk1_blue", o_blue, 10'h354);
    chk("blk1_tick", {9'd0, o_tick}, 10'd1);
    step(1'b1);
    chk("blk2_blue", o_blue, 10'h0AB);
    chk("blk2_green", o_green, 10'h354);
    chk("blk2_red", o_red, 10'h354);
    chk("blk2_inv_blue", i_blue, 10'h154);
    chk("blk2_inv_green", i_green, 10'h354);
    chk("blk2_inv_red", i_red, 10'h354);
    step(1'b1);
    chk("blk3_blue", o_blue, 10'h0AB);
    step(1'b0);
    chk("hold_tick", {9'd0, o_tick}, 10'd0);
    chk("hold_blue", o_blue, 10'h0AB);

    // Active pixels: blue 0x00, green 0xFF, red 0x00 on consecutive ticks.
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    step(1'b1);
    chk("act1_blue", o_blue, 10'h0AB);
    step(1'b1);
    chk("act2_blue", o_blue, 10'h100);
    chk("act2_green", o_green, 10'h200);
    chk("act2_red", o_red, 10'h100);
    chk("act2_inv_blue", i_blue, 10'h100);
    step(1'b1);
    chk("act3_blue", o_blue, 10'h3FF);
    chk("act3_green", o_green, 10'h0FF);
    chk("act3_red", o_red, 10'h3FF);
    step(1'b1);
    chk("act4_blue", o_blue, 10'h100);
    chk("act4_green", o_green, 10'h0FF);

    // Reset mid-stream while the disparity is nonzero.
    rst = 1'b1;
    step(1'b0);
    chk("mrst_blue", o_blue, 10'h354);
    chk("mrst_green", o_green, 10'h354);
    chk("mrst_tick", {9'd0, o_tick}, 10'd0);
    rst = 1'b0;
    step(1'b0);
    chk("mrst_hold", o_blue, 10'h354);
    step(1'b1);
    chk("post1_blue", o_blue, 10'h354);
    step(1'b1);
    chk("post2_blue", o_blue, 10'h100);
    chk("post2_green", o_green, 10'h200);
    chk("post2_red", o_red, 10'h100);

    // A blank pixel between active pixels restarts the disparity at zero.
    set_px(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00);
    step(1'b1);
    chk("tr1_blue", o_blue, 10'h3FF);
    set_px(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    step(1'b1);
    chk("tr2_blue", o_blue, 10'h154);
    chk("tr2_inv_blue", i_blue, 10'h0AB);
    step(1'b1);
    chk("tr3_blue", o_blue, 10'h100);
    chk("tr3_green", o_green, 10'h200);

    // Random stream with irregular strobe gaps, compared to the model.
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    m_b1 = 1'b1; m_h1 = 1'b0; m_v1 = 1'b0; m_tk = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_qm1[c] = '0;
      m_cnt[c] = 0;
      m_out[c] = 10'h354;
    end
    for (int k = 0; k < 600; k++) begin
      t = ($urandom_range(0, 2) == 0) || ((k % 11) < 3);
      set_px($urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
      din[0] = blue; din[1] = green; din[2] = red;
      step(t);
      if (t) begin
        for (int c = 0; c < 3; c++) begin
          if (m_b1) begin
            m_out[c] = (c == 0) ? m_ctrl(m_v1, m_h1) : m_ctrl(1'b0, 1'b0);
            m_cnt[c] = 0;
          end else begin
            m_out[c] = m_enc(m_qm1[c], m_cnt[c], c_new);
            m_cnt[c] = c_new;
          end
          m_qm1[c] = m_qm(din[c]);
        end
        m_b1 = blank; m_h1 = hs; m_v1 = vs;
      end
      m_tk = t;
      chk("rnd_blue", o_blue, m_out[0]);
      chk("rnd_green", o_green, m_out[1]);
      chk("rnd_red", o_red, m_out[2]);
      chk("rnd_tick", {9'd0, o_tick}, {9'd0, m_tk});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Downstream stage of the console top level. Consumes the pixel-rate video stream: the per-pixel rise strobe, blank, hsync/vsync and 8-bit RGB.
- Produces three DVI 1.0 TMDS 10-bit symbols per pixel, one each for blue, green and red.
- Runs on the system clock. The pipeline advances only on the pixel strobe.
- Output words feed a vendor 10:1 serializer, which is outside this block.

Parameters:
- P_invert_sync, 0, when 1 hsync and vsync are inverted before control-symbol encoding.
- P_stages, 2, pipeline depth in pixel ticks; only 2 is supported, any other value is a compile-time $error.

Ports:
- I_clock  in  1  system clock; one clock.
- I_reset  in  1  reset, synchronous, active-high.
- I_tick  in  1  pixel strobe, one I_clock cycle wide.
- I_vid_blank  in  1  1 = blanking period; emit control symbols.
- I_vid_hsync  in  1  horizontal sync.
- I_vid_vsync  in  1  vertical sync.
- I_vid_red  in  8  red pixel.
- I_vid_green  in  8  green pixel.
- I_vid_blue  in  8  blue pixel.
- O_tmds_blue  out  10  channel 0 symbol, bit 0 transmitted first.
- O_tmds_green  out  10  channel 1 symbol.
- O_tmds_red  out  10  channel 2 symbol.
- O_tick  out  1  high for one I_clock cycle when the O_tmds_* words change.

Behaviour:
- Reset is synchronous and active-high; it takes priority over I_tick. On reset:
  - all O_tmds_* = 10'b1101010100;
  - all running-disparity counters = 0;
  - pipeline registers hold blank=1, syncs=0;
  - O_tick = 0.
- Reset asserted mid-stream: outputs go to the reset values on the next edge. The first symbols after release come from fresh inputs, two ticks later.
- Stage 1, on an I_tick edge:
  - Latch blank and the (optionally inverted) syncs.
  - Per channel, compute 9-bit q_m. Let N1(D) = popcount of D.
  - XNOR path when N1(D)>4, or N1(D)==4 and D[0]==0:
    - q_m[0]=D[0];
    - q_m[i]=~(q_m[i-1]^D[i]) for i=1..7;
    - q_m[8]=0.
  - Otherwise XOR path, same chain with ^, and q_m[8]=1.
- Stage 2, on an I_tick edge. Per channel, a signed 5-bit disparity counter cnt (range -10..+10). Let n1/n0 = ones/zeros of q_m[7:0].
  - Blank=1: output a control symbol from {C1,C0}, and cnt <= 0.
    - 00 -> 1101010100
    - 01 -> 0010101011
    - 10 -> 0101010100
    - 11 -> 1010101011
    - Blue uses C0=hsync, C1=vsync. Green and red use 00.
  - Blank=0, case cnt==0 or n1==n0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
    - cnt += q_m[8] ? (n1-n0) : (n0-n1).
  - Blank=0, case (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
    - out = {1, q_m[8], ~q_m[7:0]};
    - cnt += 2*q_m[8] + (n0-n1).
  - Blank=0, otherwise:
    - out = {0, q_m[8], q_m[7:0]};
    - cnt += (n1-n0) - 2*(~q_m[8]).
- All disparity arithmetic is signed, evaluated at 6 bits or wider, then stored at 5 bits. No saturation is needed because the range is bounded.
- Latency:
  - A pixel sampled on tick k appears on O_tmds_* in the cycle after tick k+1.
  - O_tick = I_tick delayed one I_clock cycle; it is forced to 0 during reset.
- No I_tick: all state holds. Outputs are stable between ticks.
- I_tick held high on consecutive cycles: each cycle is a separate pixel.
- Blank transitions take effect per pixel, with no extra delay. The first active pixel after blank starts from cnt=0.
- The three channels are independent. The disparity of one channel never affects another.

Test Plan:
- Reset, then no ticks -> all O_tmds_* = 0x354 and O_tick=0, held indefinitely.
- Blank=1, hsync=1, vsync=0, 3 ticks -> after 2 ticks blue=0x0AB, green=red=0x354. With P_invert_sync=1: blue=0x154.
- Blank=0, blue=0x00 for three consecutive ticks after blanking -> blue outputs 0x100, 0x3FF, 0x100. Disparity goes -8, +2, -6.
- Blank=0, green=0xFF, one tick after blanking -> green=0x200, disparity -8. Red held at 0x00 in the same pixel gives red=0x100, showing the channels are independent.
- Assert I_reset mid-stream with disparity nonzero, release, feed blue=0x00 -> first symbol is 0x100 (cnt restarted at 0). No stale symbol appears on O_tmds_*.
- Random RGB/blank stream with irregular tick gaps, compared to a reference model -> bit-exact match. Running disparity stays within ±10. Outputs are unchanged on non-tick cycles.
